bcd_acumulador: RTL and testbench



---
 rtl/bcd_acumulador_pkg.sv | 27 ++
 rtl/bcd_acumulador_bcd_a_bin.sv | 68 ++++++
 rtl/bcd_acumulador.sv | 154 +++++++++++++++
 tb/tb_bcd_acumulador.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_acumulador_pkg.sv
// Purpose : shared types and constants for the BCD accumulator slice.
// Latency : n/a (package only).
// Backpres: n/a.
package bcd_pkg;

    // Operation code as driven on the 2-bit op input.
    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        EXEC = 2'b10
    } estado_e;

    // Largest legal value of a single BCD nibble.
    localparam logic [3:0] BCD_MAX_DIGITO = 4'd9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_acumulador_bcd_a_bin.sv
// Purpose : sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Latency : NDIG cycles after the start edge; done_o is high during the last digit cycle.
// Backpres: none; start_i must only be pulsed while the converter is idle.
// Ports   : clk_i, rst_ni (async, active-low), start_i + digitos_i (operand capture),
//           done_o (last digit being folded in), invalido_o (some nibble > 9),
//           valor_o (binary result, stable once done_o has been seen).
module bcd_a_bin
    import bcd_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [4*NDIG-1:0] digitos_i,
    output logic              done_o,
    output logic              invalido_o,
    output logic [4*NDIG-1:0] valor_o
);

    localparam int CW   = 4 * NDIG;
    localparam int CNTW = $clog2(NDIG + 1);
    localparam logic [CNTW-1:0] ULTIMO = CNTW'(NDIG - 1);

    logic [CW-1:0]   sr_q;     // remaining digits, next one in the top nibble
    logic [CW-1:0]   conv_q;
    logic [CNTW-1:0] cnt_q;
    logic            busy_q;
    logic            inv_q;

    logic [3:0]      digito;
    logic [CW-1:0]   conv_d;

    assign digito = sr_q[CW-1 -: 4];

    // Even with invalid nibbles the result fits in CW bits (15 * 11..1 < 2^CW),
    // so the CW-bit multiply never loses information.
    assign conv_d = conv_q * CW'(10) + CW'(digito);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q   <= '0;
            conv_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            inv_q  <= 1'b0;
        end else if (start_i) begin
            sr_q   <= digitos_i;
            conv_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            inv_q  <= 1'b0;
        end else if (busy_q) begin
            conv_q <= conv_d;
            inv_q  <= inv_q | (digito > BCD_MAX_DIGITO);
            sr_q   <= sr_q << 4;
            cnt_q  <= cnt_q + CNTW'(1);
            if (cnt_q == ULTIMO) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o     = busy_q && (cnt_q == ULTIMO);
    assign invalido_o = inv_q;
    assign valor_o    = conv_q;

endmodule

// File: rtl/bcd_acumulador.sv
// Purpose : BCD operand entry into a saturating binary running total (add/sub/load/clear).
// Latency : NDIG+1 cycles for numeric ops, 1 cycle for CLEAR; listo pulses on completion.
// Backpres: cargar is only accepted while ocupado=0; requests while busy are dropped.
// Ports   : clk, n_reset (async, active-low), digitos/op/cargar (request),
//           ocupado/listo (status), numero_guardado (total), desborde/digito_invalido (sticky).
module bcd_acumulador
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int RW   = 12
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [4*NDIG-1:0] digitos,
    input  logic [1:0]        op,
    input  logic              cargar,
    output logic              ocupado,
    output logic              listo,
    output logic [RW-1:0]     numero_guardado,
    output logic              desborde,
    output logic              digito_invalido
);

    localparam int CW = 4 * NDIG;
    // One guard bit above the wider of total/operand so sums never wrap.
    localparam int AW = max_int(RW, CW) + 1;
    localparam logic [AW-1:0] TOT_MAX = (AW'(1) << RW) - AW'(1);

    estado_e       estado_q;
    op_e           op_q;
    logic [RW-1:0] total_q;
    logic          desborde_q;
    logic          invalido_q;
    logic          listo_q;
    logic          ocupado_q;

    logic          arranque;
    logic          conv_done;
    logic          conv_inv;
    logic [CW-1:0] conv_val;

    logic [RW-1:0] total_d;
    logic          desborde_d;
    logic          invalido_d;
    logic [AW-1:0] tot_ext;
    logic [AW-1:0] conv_ext;

    assign arranque = (estado_q == IDLE) && cargar && (op_e'(op) != OP_CLEAR);

    bcd_a_bin #(
        .NDIG (NDIG)
    ) u_conv (
        .clk_i      (clk),
        .rst_ni     (n_reset),
        .start_i    (arranque),
        .digitos_i  (digitos),
        .done_o     (conv_done),
        .invalido_o (conv_inv),
        .valor_o    (conv_val)
    );

    assign tot_ext  = AW'(total_q);
    assign conv_ext = AW'(conv_val);

    // Result of the pending operation, committed on the EXEC edge.
    always_comb begin
        total_d    = total_q;
        desborde_d = desborde_q;
        invalido_d = invalido_q;
        if (op_q == OP_CLEAR) begin
            total_d    = '0;
            desborde_d = 1'b0;
            invalido_d = 1'b0;
        end else if (conv_inv) begin
            invalido_d = 1'b1;
        end else begin
            case (op_q)
                OP_ADD: begin
                    if ((tot_ext + conv_ext) > TOT_MAX) begin
                        total_d    = '1;
                        desborde_d = 1'b1;
                    end else begin
                        total_d = total_q + RW'(conv_val);
                    end
                end
                OP_SUB: begin
                    if (conv_ext > tot_ext) begin
                        total_d    = '0;
                        desborde_d = 1'b1;
                    end else begin
                        total_d = total_q - RW'(conv_val);
                    end
                end
                OP_LOAD: begin
                    if (conv_ext > TOT_MAX) begin
                        total_d    = '1;
                        desborde_d = 1'b1;
                    end else begin
                        total_d = RW'(conv_val);
                    end
                end
                default: begin
                    total_d = total_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            estado_q   <= IDLE;
            op_q       <= OP_ADD;
            total_q    <= '0;
            desborde_q <= 1'b0;
            invalido_q <= 1'b0;
            listo_q    <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (cargar) begin
                        op_q      <= op_e'(op);
                        ocupado_q <= 1'b1;
                        estado_q  <= (op_e'(op) == OP_CLEAR) ? EXEC : CONV;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        estado_q <= EXEC;
                    end
                end
                EXEC: begin
                    total_q    <= total_d;
                    desborde_q <= desborde_d;
                    invalido_q <= invalido_d;
                    listo_q    <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estado_q   <= IDLE;
                end
                default: begin
                    estado_q <= IDLE;
                end
            endcase
        end
    end

    assign ocupado         = ocupado_q;
    assign listo           = listo_q;
    assign numero_guardado = total_q;
    assign desborde        = desborde_q;
    assign digito_invalido = invalido_q;

endmodule

// File: tb/tb_bcd_acumulador.sv
// Purpose : directed self-checking bench for bcd_acumulador (NDIG=3, RW=12).
// Latency : checks NDIG+1 / 1 cycle completion timing.
// Backpres: checks that requests during a busy window are dropped.
module tb_bcd_acumulador;

    localparam int NDIG = 3;
    localparam int RW   = 12;

    logic              clk;
    logic              n_reset;
    logic [4*NDIG-1:0] digitos;
    logic [1:0]        op;
    logic              cargar;
    logic              ocupado;
    logic              listo;
    logic [RW-1:0]     numero_guardado;
    logic              desborde;
    logic              digito_invalido;

    int n_checks = 0;
    int n_errors = 0;

    bcd_acumulador #(
        .NDIG (NDIG),
        .RW   (RW)
    ) dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .digitos         (digitos),
        .op              (op),
        .cargar          (cargar),
        .ocupado         (ocupado),
        .listo           (listo),
        .numero_guardado (numero_guardado),
        .desborde        (desborde),
        .digito_invalido (digito_invalido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request, then follow it to completion and check the result.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [11:0] d,
                         input int exp_tot, input logic exp_desb, input logic exp_inv,
                         input int exp_lat);
        int n;
        op      = o;
        digitos = d;
        cargar  = 1'b1;
        @(posedge clk);
        #1;
        cargar  = 1'b0;
        digitos = 12'hFFF;   // operand may change freely after acceptance
        op      = 2'b00;
        chk({tag, "_ocupado_on"}, 32'(ocupado), 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!listo && n < 20);
        chk({tag, "_latencia"}, 32'(n), 32'(exp_lat));
        chk({tag, "_total"}, 32'(numero_guardado), 32'(exp_tot));
        chk({tag, "_desborde"}, 32'(desborde), 32'(exp_desb));
        chk({tag, "_invalido"}, 32'(digito_invalido), 32'(exp_inv));
        chk({tag, "_ocupado_off"}, 32'(ocupado), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_listo_pulso"}, 32'(listo), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lc;
        n_reset = 1'b0;
        cargar  = 1'b0;
        op      = 2'b00;
        digitos = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_total", 32'(numero_guardado), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_desborde", 32'(desborde), 32'd0);
        chk("rst_invalido", 32'(digito_invalido), 32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // op codes: 0 ADD, 1 SUB, 2 LOAD, 3 CLEAR
        do_op("load156", 2'd2, 12'h156, 156, 1'b0, 1'b0, 4);
        do_op("add157",  2'd0, 12'h157, 313, 1'b0, 1'b0, 4);
        do_op("sub400",  2'd1, 12'h400, 0,   1'b1, 1'b0, 4);
        do_op("clear1",  2'd3, 12'h000, 0,   1'b0, 1'b0, 1);

        do_op("load999", 2'd2, 12'h999, 999,  1'b0, 1'b0, 4);
        do_op("add999a", 2'd0, 12'h999, 1998, 1'b0, 1'b0, 4);
        do_op("add999b", 2'd0, 12'h999, 2997, 1'b0, 1'b0, 4);
        do_op("add999c", 2'd0, 12'h999, 3996, 1'b0, 1'b0, 4);
        do_op("add_sat", 2'd0, 12'h999, 4095, 1'b1, 1'b0, 4);
        do_op("sub095",  2'd1, 12'h095, 4000, 1'b1, 1'b0, 4);
        do_op("add1A5",  2'd0, 12'h1A5, 4000, 1'b1, 1'b1, 4);
        do_op("clear2",  2'd3, 12'h000, 0,    1'b0, 1'b0, 1);

        // cargar held across the whole busy window: only one ADD executes
        lc      = 0;
        op      = 2'd0;
        digitos = 12'h001;
        cargar  = 1'b1;
        @(posedge clk);
        #1;
        chk("win_ocupado0", 32'(ocupado), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (listo) lc++;
            chk($sformatf("win_ocupado%0d", i), 32'(ocupado), (i < 4) ? 32'd1 : 32'd0);
        end
        cargar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (listo) lc++;
        end
        chk("win_listo_count", 32'(lc), 32'd1);
        chk("win_total", 32'(numero_guardado), 32'd1);
        chk("win_ocupado_end", 32'(ocupado), 32'd0);

        // async reset in the middle of a conversion
        op      = 2'd0;
        digitos = 12'h500;
        cargar  = 1'b1;
        @(posedge clk);
        #1;
        cargar = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_ocupado_pre", 32'(ocupado), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_total", 32'(numero_guardado), 32'd0);
        chk("mid_ocupado", 32'(ocupado), 32'd0);
        chk("mid_listo", 32'(listo), 32'd0);
        chk("mid_desborde", 32'(desborde), 32'd0);
        chk("mid_invalido", 32'(digito_invalido), 32'd0);
        #2;
        n_reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(ocupado), 32'd0);
        chk("post_rst_total", 32'(numero_guardado), 32'd0);
        do_op("load042", 2'd2, 12'h042, 42, 1'b0, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
